// File: rtl/logic_pll_lock_service_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : logic_pll_lock_service_multi_if                           |
// | Purpose  : Control/status bundle between a PLL lock service and the  |
// |            logic that enables, relocks and observes its channels.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface logic_pll_lock_service_multi_if #(
    parameter int PLLS        = 1,
    parameter int MAX_RETRIES = 3
);
    // Retry counter width per channel; one bit minimum so a zero retry
    // limit still yields a legal vector.
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic [PLLS-1:0]    enable;
    logic [PLLS-1:0]    relock;
    logic [PLLS-1:0]    fault_clear;
    logic [PLLS-1:0]    pll_locked;
    logic [PLLS-1:0]    pll_reset;
    logic [PLLS-1:0]    locked;
    logic [PLLS-1:0]    fault;
    logic [PLLS*RW-1:0] retry_count;
    logic               all_locked;

    // Controller / PLL side: drives requests and raw lock, observes status
    modport master (
        output enable, relock, fault_clear, pll_locked,
        input  pll_reset, locked, fault, retry_count, all_locked
    );

    // Lock service side
    modport slave (
        input  enable, relock, fault_clear, pll_locked,
        output pll_reset, locked, fault, retry_count, all_locked
    );
endinterface
`default_nettype wire

// File: rtl/logic_pll_lock_service_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : logic_pll_lock_service_multi                              |
// | Purpose  : Supervises PLLS independent PLLs. Each channel pulses the |
// |            PLL reset, waits a bounded time for a filtered lock,      |
// |            retries on timeout and latches a fault after too many     |
// |            consecutive failures. all_locked gates the reset tree.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module logic_pll_lock_service_multi #(
    parameter int PLLS              = 1,
    parameter int RESET_DURATION    = 2,
    parameter int WAIT_FOR_LOCK     = 1_000_000,
    parameter int PLL_LOCKED_STAGES = 8,
    parameter int MAX_RETRIES       = 3
) (
    input  wire logic                     aclk,
    input  wire logic                     areset,
    logic_pll_lock_service_multi_if.slave bus
);

    localparam int c_CNT_MAX = (RESET_DURATION > WAIT_FOR_LOCK) ? RESET_DURATION : WAIT_FOR_LOCK;
    localparam int CW        = $clog2(c_CNT_MAX + 1);
    localparam int RW        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int c_MR_M1   = (MAX_RETRIES > 0) ? MAX_RETRIES - 1 : 0;

    localparam logic [CW-1:0] c_CNT_RESET = CW'(RESET_DURATION);
    localparam logic [CW-1:0] c_CNT_WAIT  = CW'(WAIT_FOR_LOCK);
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);

    localparam logic [RW-1:0] c_RETRY_FAULT = RW'(MAX_RETRIES);
    localparam logic [RW-1:0] c_RETRY_LAST  = RW'(c_MR_M1);
    localparam logic [RW-1:0] c_RETRY_SAT   = {RW{1'b1}};
    localparam logic [RW-1:0] c_RETRY_ONE   = RW'(1);

    localparam logic [2:0] c_ST_DISABLED = 3'd0;
    localparam logic [2:0] c_ST_RESET    = 3'd1;
    localparam logic [2:0] c_ST_WAIT     = 3'd2;
    localparam logic [2:0] c_ST_LOCKED   = 3'd3;
    localparam logic [2:0] c_ST_FAULT    = 3'd4;

    logic [PLLS-1:0] w_pll_reset;
    logic [PLLS-1:0] w_locked;
    logic [PLLS-1:0] w_fault;
    logic            r_all_locked;

    generate
        for (genvar gi = 0; gi < PLLS; gi++) begin : g_ch
            logic [2:0]                   r_state;
            logic [CW-1:0]                r_cnt;
            logic [RW-1:0]                r_retry;
            logic [PLL_LOCKED_STAGES-1:0] r_q;
            logic                         r_stable;
            logic                         r_filtered;
            logic                         w_hold;

            // The PLL is held in reset in these states, so its lock output
            // is meaningless and the filter history is discarded.
            assign w_hold = (r_state == c_ST_RESET) ||
                            (r_state == c_ST_FAULT) ||
                            (r_state == c_ST_DISABLED);

            // Shift raw lock into the filter; stable = all ones, filtered = any one
            always_ff @(posedge aclk) begin
                if (areset) begin
                    r_q        <= '0;
                    r_stable   <= 1'b0;
                    r_filtered <= 1'b0;
                end else begin
                    if (w_hold) begin
                        r_q <= '0;
                    end else begin
                        r_q <= {bus.pll_locked[gi], r_q[PLL_LOCKED_STAGES-1:1]};
                    end
                    r_stable   <= &r_q;
                    r_filtered <= |r_q;
                end
            end

            // Channel supervisor: reset pulse, lock wait, retry and fault tracking
            always_ff @(posedge aclk) begin
                if (areset) begin
                    r_state <= c_ST_RESET;
                    r_cnt   <= c_CNT_RESET;
                    r_retry <= '0;
                end else if (!bus.enable[gi]) begin
                    r_state <= c_ST_DISABLED;
                    r_retry <= '0;
                end else begin
                    case (r_state)
                        c_ST_DISABLED: begin
                            r_state <= c_ST_RESET;
                            r_cnt   <= c_CNT_RESET;
                        end
                        c_ST_RESET: begin
                            if (bus.relock[gi]) begin
                                r_cnt <= c_CNT_RESET;
                            end else if (r_cnt == c_CNT_ONE) begin
                                r_state <= c_ST_WAIT;
                                r_cnt   <= c_CNT_WAIT;
                            end else begin
                                r_cnt <= r_cnt - c_CNT_ONE;
                            end
                        end
                        c_ST_WAIT: begin
                            if (bus.relock[gi]) begin
                                r_state <= c_ST_RESET;
                                r_cnt   <= c_CNT_RESET;
                            end else if (r_stable) begin
                                // A lock on the timeout cycle still counts as a lock
                                r_state <= c_ST_LOCKED;
                                r_retry <= '0;
                            end else if (r_cnt == c_CNT_ONE) begin
                                if ((MAX_RETRIES != 0) && (r_retry == c_RETRY_LAST)) begin
                                    r_state <= c_ST_FAULT;
                                    r_retry <= c_RETRY_FAULT;
                                end else begin
                                    r_state <= c_ST_RESET;
                                    r_cnt   <= c_CNT_RESET;
                                    if (r_retry != c_RETRY_SAT) begin
                                        r_retry <= r_retry + c_RETRY_ONE;
                                    end
                                end
                            end else begin
                                r_cnt <= r_cnt - c_CNT_ONE;
                            end
                        end
                        c_ST_LOCKED: begin
                            // Lock loss is not a failed attempt; retry_count is kept
                            if (bus.relock[gi] || !r_filtered) begin
                                r_state <= c_ST_RESET;
                                r_cnt   <= c_CNT_RESET;
                            end
                        end
                        c_ST_FAULT: begin
                            if (bus.fault_clear[gi]) begin
                                r_state <= c_ST_RESET;
                                r_cnt   <= c_CNT_RESET;
                                r_retry <= '0;
                            end
                        end
                        default: begin
                            r_state <= c_ST_RESET;
                            r_cnt   <= c_CNT_RESET;
                            r_retry <= '0;
                        end
                    endcase
                end
            end

            assign w_pll_reset[gi]                 = w_hold;
            assign w_locked[gi]                    = (r_state == c_ST_LOCKED);
            assign w_fault[gi]                     = (r_state == c_ST_FAULT);
            assign bus.retry_count[gi*RW +: RW]    = r_retry;
        end
    endgenerate

    // Aggregate lock: every enabled channel locked, with at least one enabled
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_all_locked <= 1'b0;
        end else begin
            r_all_locked <= (|bus.enable) && (&(w_locked | ~bus.enable));
        end
    end

    assign bus.pll_reset  = w_pll_reset;
    assign bus.locked     = w_locked;
    assign bus.fault      = w_fault;
    assign bus.all_locked = r_all_locked;

endmodule
`default_nettype wire
